// File: rtl/md_sched.sv
// Multiply/divide scheduler owning HI/LO: latches operands at issue, counts down a fixed latency, then commits.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles after issue; MTHI/MTLO update HI/LO on the next edge.
// Backpressure: stall holds F/D while an op is in flight (or issuing) and D needs HI/LO; starts while busy are dropped.
//
// Ports:
//   clk, reset      : clock (rising edge) and synchronous active-high reset
//   start, op       : E-stage issue strobe and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   rs, rt          : forwarded operands, captured at issue
//   md_req          : D-stage instruction touches HI/LO
//   hi, lo          : architectural HI/LO registers
//   busy, done      : op in flight / one-cycle commit pulse
//   stall           : freeze F/D, bubble E
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        md_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   rs_q, rs_d;
    logic [31:0]   rt_q, rt_d;
    logic [1:0]    op_q, op_d;
    logic          done_q, done_d;

    // Datapath on the latched operands. op_q[0]==0 selects the signed flavour,
    // op_q[1] selects divide.
    logic        sgn;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, den, uq, ur, quo, rem;
    logic        div_zero;
    logic [63:0] result;

    always_comb begin
        sgn   = ~op_q[0];
        // Sign/zero extension to 64 bits makes one low-64 product correct for
        // both signed and unsigned multiply.
        ext_a = {{32{sgn & rs_q[31]}}, rs_q};
        ext_b = {{32{sgn & rt_q[31]}}, rt_q};
        prod  = ext_a * ext_b;

        // Divide on magnitudes, then fix signs. Magnitude of 0x80000000 stays
        // 0x80000000 as an unsigned value, which keeps the overflow case exact.
        mag_a = (sgn & rs_q[31]) ? (~rs_q + 32'd1) : rs_q;
        mag_b = (sgn & rt_q[31]) ? (~rt_q + 32'd1) : rt_q;
        den   = (mag_b == 32'd0) ? 32'd1 : mag_b;
        uq    = mag_a / den;
        ur    = mag_a % den;
        quo   = (sgn & (rs_q[31] ^ rt_q[31])) ? (~uq + 32'd1) : uq;
        rem   = (sgn & rs_q[31]) ? (~ur + 32'd1) : ur;

        div_zero = op_q[1] & (rt_q == 32'd0);
        result   = op_q[1] ? {rem, quo} : prod;
    end

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        op_d   = op_q;
        done_d = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                // Divide by zero still burns the full latency and pulses done,
                // but leaves HI/LO alone.
                if (!div_zero) begin
                    hi_d = result[63:32];
                    lo_d = result[31:0];
                end
                done_d = 1'b1;
            end
        end else if (start) begin
            case (op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    rs_d  = rs;
                    rt_d  = rt;
                    op_d  = op[1:0];
                    cnt_d = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
                3'd4:    hi_d = rs;
                3'd5:    lo_d = rs;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            op_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            op_q   <= op_d;
            done_q <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (cnt_q != '0);
    assign done = done_q;
    // Include the issue cycle so a back-to-back HI/LO consumer cannot slip past.
    assign stall = md_req & (busy | (start & ~op[2]));

endmodule
